// File: rtl/timer_pkg.sv
// Shared definitions for the timer register block: register map, TSR bit positions
// and the bus responder state encoding.
package timer_pkg;

   localparam logic [7:0] ADDR_TCR  = 8'h00;
   localparam logic [7:0] ADDR_TDR  = 8'h01;
   localparam logic [7:0] ADDR_TSR  = 8'h02;
   localparam logic [7:0] ADDR_TCNT = 8'h03;

   localparam int unsigned TSR_OVF = 0;
   localparam int unsigned TSR_UDF = 1;

   typedef enum logic [1:0] {
      StIdle,
      StSetup,
      StAccess
   } apb_state_t;

endpackage

// File: rtl/timer_apb_regif_if.sv
// APB-style bus bundle between the CPU bus model (master) and the timer
// register responder (slave).
interface timer_apb_regif_if;

   logic       psel;
   logic       penable;
   logic       pwrite;
   logic [7:0] paddr;
   logic [7:0] pwdata;
   logic [7:0] prdata;
   logic       pready;
   logic       pslverr;

   modport master (
      output psel, penable, pwrite, paddr, pwdata,
      input  prdata, pready, pslverr
   );

   modport slave (
      input  psel, penable, pwrite, paddr, pwdata,
      output prdata, pready, pslverr
   );

endinterface

// File: rtl/timer_tsr_flag.sv
// Single sticky status bit: set by a hardware event, cleared by request;
// a set in the same cycle as a clear wins.
module timer_tsr_flag (
   input  logic clk,
   input  logic rst_n,
   input  logic set_i,
   input  logic clr_i,
   output logic q_o
);

   logic flag_q, flag_d;

   always_comb begin
      flag_d = flag_q;
      if (set_i) begin
         flag_d = 1'b1;
      end else if (clr_i) begin
         flag_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         flag_q <= 1'b0;
      end else begin
         flag_q <= flag_d;
      end
   end

   assign q_o = flag_q;

endmodule

// File: rtl/timer_apb_regif.sv
// Timer register responder: TCR/TDR/TSR/TCNT behind an APB-style bus with wait states.
// Optional macro TSR_CLEAR_ON_READ_EN makes a read of TSR clear both flags.
module timer_apb_regif
   import timer_pkg::*;
#(
   parameter int unsigned WAIT_CYCLES = 1,
   parameter logic [7:0]  TCR_RST     = 8'h00,
   parameter logic [7:0]  TDR_RST     = 8'h00
) (
   input  logic               clk,
   input  logic               rst_n,
   timer_apb_regif_if.slave   bus,
   input  logic               ovf_set_i,
   input  logic               udf_set_i,
   input  logic [7:0]         tcnt_i,
   output logic [7:0]         tcr_o,
   output logic [7:0]         tdr_o,
   output logic [1:0]         tsr_o
);

   apb_state_t state_q, state_d;
   logic [2:0] cnt_q, cnt_d;
   logic [7:0] tcr_q, tdr_q;
   logic       ovf, udf;

   logic       complete;
   logic       err;
   logic       wr_ok;
   logic       rd_tsr;
   logic       ovf_clr, udf_clr;
   logic [7:0] rdata;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= StIdle;
         cnt_q   <= 3'd0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      unique case (state_q)
         StIdle: begin
            if (bus.psel && !bus.penable) state_d = StSetup;
         end
         StSetup: begin
            if (!bus.psel) begin
               state_d = StIdle;
            end else if (bus.penable) begin
               state_d = StAccess;
               cnt_d   = 3'(WAIT_CYCLES);
            end
         end
         StAccess: begin
            // Losing psel or penable mid-access aborts without completing.
            if (!bus.psel || !bus.penable) begin
               state_d = StIdle;
            end else if (cnt_q != 3'd0) begin
               cnt_d = cnt_q - 3'd1;
            end else begin
               state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_comb begin
      complete = (state_q == StAccess) && bus.psel && bus.penable && (cnt_q == 3'd0);
      err      = complete && ((bus.paddr > ADDR_TCNT) || (bus.pwrite && bus.paddr == ADDR_TCNT));
      wr_ok    = complete && bus.pwrite && !err;
      rd_tsr   = complete && !bus.pwrite && (bus.paddr == ADDR_TSR);
      rdata    = 8'h00;
      if (complete && !bus.pwrite) begin
         unique case (bus.paddr)
            ADDR_TCR:  rdata = tcr_q;
            ADDR_TDR:  rdata = tdr_q;
            ADDR_TSR:  rdata = {6'd0, udf, ovf};
            ADDR_TCNT: rdata = tcnt_i;
            default:   rdata = 8'h00;
         endcase
      end
   end

   assign bus.pready  = complete;
   assign bus.pslverr = err;
   assign bus.prdata  = rdata;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tcr_q <= TCR_RST;
         tdr_q <= TDR_RST;
      end else if (wr_ok) begin
         if (bus.paddr == ADDR_TCR) tcr_q <= bus.pwdata;
         if (bus.paddr == ADDR_TDR) tdr_q <= bus.pwdata;
      end
   end

`ifdef TSR_CLEAR_ON_READ_EN
   assign ovf_clr = (wr_ok && bus.paddr == ADDR_TSR && bus.pwdata[TSR_OVF]) || rd_tsr;
   assign udf_clr = (wr_ok && bus.paddr == ADDR_TSR && bus.pwdata[TSR_UDF]) || rd_tsr;
`else
   assign ovf_clr = wr_ok && bus.paddr == ADDR_TSR && bus.pwdata[TSR_OVF];
   assign udf_clr = wr_ok && bus.paddr == ADDR_TSR && bus.pwdata[TSR_UDF];
`endif

   timer_tsr_flag u_ovf (
      .clk   (clk),
      .rst_n (rst_n),
      .set_i (ovf_set_i),
      .clr_i (ovf_clr),
      .q_o   (ovf)
   );

   timer_tsr_flag u_udf (
      .clk   (clk),
      .rst_n (rst_n),
      .set_i (udf_set_i),
      .clr_i (udf_clr),
      .q_o   (udf)
   );

   assign tcr_o = tcr_q;
   assign tdr_o = tdr_q;
   assign tsr_o = {udf, ovf};

endmodule

// File: tb/tb_timer_apb_regif.sv
// Directed plus randomized bench for timer_apb_regif against a transfer-level register model.
module tb_timer_apb_regif;
   import timer_pkg::*;

   localparam int unsigned W = 1;

   logic       clk;
   logic       rst_n;
   logic       ovf_set_i, udf_set_i;
   logic [7:0] tcnt_i;
   logic [7:0] tcr_o, tdr_o;
   logic [1:0] tsr_o;

   int total = 0;
   int bad   = 0;

   // Reference model state
   logic [7:0] m_tcr, m_tdr;
   bit         m_ovf, m_udf;

   timer_apb_regif_if bus ();

   timer_apb_regif #(
      .WAIT_CYCLES (W),
      .TCR_RST     (8'h00),
      .TDR_RST     (8'h00)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .bus       (bus),
      .ovf_set_i (ovf_set_i),
      .udf_set_i (udf_set_i),
      .tcnt_i    (tcnt_i),
      .tcr_o     (tcr_o),
      .tdr_o     (tdr_o),
      .tsr_o     (tsr_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_tcr = 8'h00;
      m_tdr = 8'h00;
      m_ovf = 0;
      m_udf = 0;
   endtask

   task automatic chk_outputs(input string tag);
      chk({tag, "_tcr"}, {24'd0, tcr_o}, {24'd0, m_tcr});
      chk({tag, "_tdr"}, {24'd0, tdr_o}, {24'd0, m_tdr});
      chk({tag, "_tsr"}, {30'd0, tsr_o}, {30'd0, m_udf, m_ovf});
   endtask

   // Full transfer; eo/eu pulse the hardware events during the completion cycle.
   task automatic xfer(input bit wr, input logic [7:0] a, input logic [7:0] d,
                       input bit eo, input bit eu, input string tag);
      int         w;
      bit         done;
      logic [7:0] rd;
      logic       er;
      logic [7:0] exp_rd;
      bit         exp_er;
      @(negedge clk);
      chk({tag, "_idle_pready"}, {31'd0, bus.pready}, 0);
      bus.psel = 1'b1; bus.penable = 1'b0; bus.pwrite = wr; bus.paddr = a; bus.pwdata = d;
      @(negedge clk);
      chk({tag, "_setup_prdata"}, {24'd0, bus.prdata}, 0);
      bus.penable = 1'b1;
      w = 0;
      done = 0;
      for (int i = 0; i < 20 && !done; i++) begin
         @(negedge clk);
         if (bus.pready === 1'b1) done = 1;
         else w++;
      end
      chk({tag, "_completed"}, {31'd0, done}, 1);
      rd = bus.prdata;
      er = bus.pslverr;
      ovf_set_i = eo;
      udf_set_i = eu;
      chk({tag, "_waits"}, w, W);

      exp_er = (a > 8'h03) || (wr && a == 8'h03);
      exp_rd = 8'h00;
      if (!wr) begin
         case (a)
            8'h00:   exp_rd = m_tcr;
            8'h01:   exp_rd = m_tdr;
            8'h02:   exp_rd = {6'd0, m_udf, m_ovf};
            8'h03:   exp_rd = tcnt_i;
            default: exp_rd = 8'h00;
         endcase
      end
      chk({tag, "_pslverr"}, {31'd0, er}, {31'd0, exp_er});
      chk({tag, "_prdata"}, {24'd0, rd}, {24'd0, exp_rd});

      if (wr && !exp_er) begin
         if (a == 8'h00) m_tcr = d;
         if (a == 8'h01) m_tdr = d;
         if (a == 8'h02) begin
            if (d[0]) m_ovf = 0;
            if (d[1]) m_udf = 0;
         end
      end
`ifdef TSR_CLEAR_ON_READ_EN
      if (!wr && a == 8'h02) begin
         m_ovf = 0;
         m_udf = 0;
      end
`endif
      m_ovf = m_ovf | eo;
      m_udf = m_udf | eu;

      @(negedge clk);
      bus.psel = 1'b0; bus.penable = 1'b0;
      ovf_set_i = 1'b0; udf_set_i = 1'b0;
      chk_outputs(tag);
   endtask

   task automatic pulse(input bit eo, input bit eu);
      @(negedge clk);
      ovf_set_i = eo; udf_set_i = eu;
      @(negedge clk);
      ovf_set_i = 1'b0; udf_set_i = 1'b0;
      m_ovf = m_ovf | eo;
      m_udf = m_udf | eu;
   endtask

   initial begin
      bit         wr;
      logic [7:0] a, d;
      rst_n = 1'b0;
      bus.psel = 1'b0; bus.penable = 1'b0; bus.pwrite = 1'b0;
      bus.paddr = 8'h00; bus.pwdata = 8'h00;
      ovf_set_i = 1'b0; udf_set_i = 1'b0; tcnt_i = 8'h00;
      model_reset();
      #23;
      chk("rst_pready", {31'd0, bus.pready}, 0);
      chk_outputs("rst");
      rst_n = 1'b1;

      xfer(0, 8'h00, 8'h00, 0, 0, "rd_tcr_rst");
      xfer(0, 8'h01, 8'h00, 0, 0, "rd_tdr_rst");
      xfer(0, 8'h02, 8'h00, 0, 0, "rd_tsr_rst");

      xfer(1, 8'h00, 8'hA5, 0, 0, "wr_tcr");
      xfer(0, 8'h00, 8'h00, 0, 0, "rd_tcr");

      for (int i = 0; i < 10; i++) begin
         pulse(1, 0);
         xfer(0, 8'h02, 8'h00, 0, 0, "rd_ovf");
         xfer(1, 8'h02, 8'h01, 0, 0, "w1c_ovf");
         xfer(0, 8'h02, 8'h00, 0, 0, "rd_ovf_clr");
      end

      xfer(1, 8'h02, 8'h02, 0, 1, "w1c_vs_set");
      xfer(0, 8'h02, 8'h00, 0, 0, "rd_set_wins");

      // Clearing udf while ovf is being set in the same cycle.
      xfer(1, 8'h02, 8'h02, 1, 0, "w1c_other");
      xfer(0, 8'h02, 8'h00, 0, 0, "rd_other");
      xfer(1, 8'h02, 8'h03, 0, 0, "w1c_both");

      tcnt_i = 8'h3C;
      xfer(1, 8'h03, 8'h55, 0, 0, "wr_tcnt");
      xfer(0, 8'h10, 8'h00, 0, 0, "rd_unmapped");
      xfer(0, 8'h03, 8'h00, 0, 0, "rd_tcnt");
      xfer(1, 8'hC7, 8'h77, 0, 0, "wr_unmapped");

      // Abort an ACCESS write to TDR by dropping psel during the wait cycle.
      @(negedge clk);
      bus.psel = 1'b1; bus.penable = 1'b0; bus.pwrite = 1'b1;
      bus.paddr = 8'h01; bus.pwdata = 8'hFF;
      @(negedge clk);
      bus.penable = 1'b1;
      @(negedge clk);
      bus.psel = 1'b0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         chk("abort_pready", {31'd0, bus.pready}, 0);
      end
      bus.penable = 1'b0;
      chk_outputs("abort");

      // Random traffic against the model.
      for (int i = 0; i < 60; i++) begin
         wr = 1'($urandom_range(0, 1));
         a  = ($urandom_range(0, 7) == 0) ? 8'($urandom) : 8'($urandom_range(0, 4));
         d  = 8'($urandom);
         tcnt_i = 8'($urandom);
         xfer(wr, a, d, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), "rand");
      end

      // Reset during a write completion cycle: nothing commits, bus goes quiet at once.
      pulse(1, 1);
      @(negedge clk);
      bus.psel = 1'b1; bus.penable = 1'b0; bus.pwrite = 1'b1;
      bus.paddr = 8'h00; bus.pwdata = 8'h3E;
      @(negedge clk);
      bus.penable = 1'b1;
      repeat (W + 1) @(negedge clk);
      chk("pre_rst_pready", {31'd0, bus.pready}, 1);
      rst_n = 1'b0;
      #1;
      model_reset();
      chk("midrst_pready", {31'd0, bus.pready}, 0);
      chk("midrst_pslverr", {31'd0, bus.pslverr}, 0);
      chk("midrst_prdata", {24'd0, bus.prdata}, 0);
      chk_outputs("midrst");
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      chk("postrst_pready", {31'd0, bus.pready}, 0);
      bus.psel = 1'b0; bus.penable = 1'b0;
      chk_outputs("postrst");
      xfer(0, 8'h00, 8'h00, 0, 0, "rd_after_rst");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
